// File: rtl/systolic_controller.sv
// systolic_controller: sequences clear/feed/flush/drain of an output-stationary systolic array
// Ports: clk, rst (async, active-low); start/k_len job request; busy/done status;
//   buf_rd_en/buf_addr with a_vec/b_vec operand buffer (one-cycle read latency);
//   array_clear/accumulate_enable/read_enable/row_index/array_results array control;
//   west_inputs/north_inputs skewed operands; res_valid/res_ready/res_row/res_data result rows.
//   All vectors carry lane 0 in the most significant DATA_WIDTH bits.
module systolic_controller #(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [7:0]                       k_len,
    output logic                             busy,
    output logic                             done,
    output logic                             buf_rd_en,
    output logic [7:0]                       buf_addr,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_vec,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_vec,
    output logic                             array_clear,
    output logic                             accumulate_enable,
    output logic                             read_enable,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] west_inputs,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] north_inputs,
    output logic [31:0]                      row_index,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] array_results,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [31:0]                      res_row,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] res_data
);
    localparam int N = ARRAY_SIZE;
    localparam int W = DATA_WIDTH;
    // wide enough for K=255 plus the 2N-1 cycle flush tail
    localparam int CW = $clog2(256 + 2 * N) + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;

    state_t        state;
    logic [7:0]    k_reg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] feed_end;
    logic [CW-1:0] win_end;
    logic [31:0]   row;
    logic          rd_valid;
    logic          skew_clr;
    logic          skew_en;

    // cnt is the cycle index since the first buf_rd_en; the accumulate window spans 1..K+2N-1
    assign feed_end  = CW'(k_reg) - CW'(1);
    assign win_end   = CW'(k_reg) + CW'(2 * N - 1);
    assign skew_clr  = state == CLEAR;
    assign skew_en   = state == FEED || state == FLUSH;
    assign busy      = state != IDLE;
    assign row_index = row;
    assign res_row   = row;
    assign res_data  = res_valid ? array_results : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            k_reg             <= '0;
            cnt               <= '0;
            row               <= '0;
            rd_valid          <= 1'b0;
            done              <= 1'b0;
            buf_rd_en         <= 1'b0;
            buf_addr          <= '0;
            array_clear       <= 1'b0;
            accumulate_enable <= 1'b0;
            read_enable       <= 1'b0;
            res_valid         <= 1'b0;
        end else begin
            rd_valid    <= buf_rd_en;
            array_clear <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state       <= CLEAR;
                    k_reg       <= k_len;
                    array_clear <= 1'b1;
                end
                CLEAR: begin
                    cnt               <= '0;
                    accumulate_enable <= 1'b0;
                    if (k_reg != 8'd0) begin
                        state     <= FEED;
                        buf_rd_en <= 1'b1;
                        buf_addr  <= '0;
                    end else begin
                        state       <= DRAIN;
                        read_enable <= 1'b1;
                        res_valid   <= 1'b1;
                        row         <= '0;
                    end
                end
                FEED, FLUSH: begin
                    cnt               <= cnt + CW'(1);
                    accumulate_enable <= cnt != win_end;
                    if (state == FEED) begin
                        if (cnt == feed_end) begin
                            state     <= FLUSH;
                            buf_rd_en <= 1'b0;
                        end else begin
                            buf_addr <= buf_addr + 8'd1;
                        end
                    end else if (cnt == win_end) begin
                        state       <= DRAIN;
                        read_enable <= 1'b1;
                        res_valid   <= 1'b1;
                        row         <= '0;
                    end
                end
                DRAIN: if (res_ready) begin
                    if (row == 32'(N - 1)) begin
                        state       <= DONE;
                        read_enable <= 1'b0;
                        res_valid   <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        row <= row + 32'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] a_in;
        logic [W-1:0] b_in;
        // cycles without a fresh buffer read inject zero
        assign a_in = rd_valid ? a_vec[(N-1-i)*W +: W] : '0;
        assign b_in = rd_valid ? b_vec[(N-1-i)*W +: W] : '0;
        if (i == 0) begin : g_direct
            assign west_inputs[(N-1)*W +: W]  = a_in;
            assign north_inputs[(N-1)*W +: W] = b_in;
        end else begin : g_skew
            localparam int D = i * W;
            // newest element enters at the LSB end, oldest leaves from the MSB end
            logic [D-1:0] sa;
            logic [D-1:0] sb;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sa <= '0;
                    sb <= '0;
                end else if (skew_clr) begin
                    sa <= '0;
                    sb <= '0;
                end else if (skew_en) begin
                    sa <= D'({sa, a_in});
                    sb <= D'({sb, b_in});
                end
            end
            assign west_inputs[(N-1-i)*W +: W]  = sa[D-1 -: W];
            assign north_inputs[(N-1-i)*W +: W] = sb[D-1 -: W];
        end
    end
endmodule

// File: tb/tb_systolic_controller.sv
// tb_systolic_controller: directed self-checking bench with buffer and systolic-array models
module tb_systolic_controller;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           res_ready = 1'b1;
    logic [7:0]     k_len = 8'd0;
    logic           busy, done, buf_rd_en, array_clear, accumulate_enable, read_enable, res_valid;
    logic [7:0]     buf_addr;
    logic [N*W-1:0] a_vec = '0;
    logic [N*W-1:0] b_vec = '0;
    logic [N*W-1:0] west_inputs, north_inputs, array_results, res_data;
    logic [31:0]    row_index, res_row;

    int checks = 0;
    int errors = 0;

    logic [N*W-1:0] mem_a [4];
    logic [N*W-1:0] mem_b [4];
    logic [N*W-1:0] exp_rows [4];
    logic [W-1:0]   acc [N][N];
    logic [W-1:0]   ap [N][N];
    logic [W-1:0]   bp [N][N];
    logic [W-1:0]   ai, bi;

    int cyc, clr_cnt, clr_first, rd_cnt, acc_cnt, first_rd, first_acc, last_acc, first_rv, re_cnt;
    int n_rows, done_cnt, busy_after, stall_seen, stall_bad, stall_left, w0_first, w3_first, w3_cnt;
    int idx_bad, timeout;
    logic [7:0]     addr_log [8];
    logic [31:0]    row_log [8];
    logic [N*W-1:0] data_log [8];
    logic [N*W-1:0] stall_data;

    always #5 clk = ~clk;

    systolic_controller #(.ARRAY_SIZE(N), .DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .buf_rd_en(buf_rd_en), .buf_addr(buf_addr), .a_vec(a_vec), .b_vec(b_vec),
        .array_clear(array_clear), .accumulate_enable(accumulate_enable), .read_enable(read_enable),
        .west_inputs(west_inputs), .north_inputs(north_inputs), .row_index(row_index),
        .array_results(array_results), .res_valid(res_valid), .res_ready(res_ready),
        .res_row(res_row), .res_data(res_data)
    );

    function automatic logic [W-1:0] lane(input logic [N*W-1:0] v, input int i);
        return v[(N-1-i)*W +: W];
    endfunction

    // operand buffer: one-cycle read latency, output holds between reads
    always @(posedge clk) begin
        if (buf_rd_en) begin
            a_vec <= mem_a[buf_addr[1:0]];
            b_vec <= mem_b[buf_addr[1:0]];
        end
    end

    // output-stationary array: a flows east, b flows south, each PE accumulates a*b
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (array_clear) begin
                    acc[i][j] <= '0;
                    ap[i][j]  <= '0;
                    bp[i][j]  <= '0;
                end else if (accumulate_enable) begin
                    if (j == 0) ai = lane(west_inputs, i);
                    else ai = ap[i][j-1];
                    if (i == 0) bi = lane(north_inputs, j);
                    else bi = bp[i-1][j];
                    acc[i][j] <= acc[i][j] + W'(ai * bi);
                    ap[i][j]  <= ai;
                    bp[i][j]  <= bi;
                end
            end
        end
    end

    always_comb begin
        array_results = '0;
        for (int j = 0; j < N; j++) array_results[(N-1-j)*W +: W] = acc[row_index[1:0]][j];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int k, input int stall_row, input int stall_n, input bit poke);
        int post;
        bit seen_done;
        cyc = 0; clr_cnt = 0; clr_first = -1; rd_cnt = 0; acc_cnt = 0; first_rd = -1;
        first_acc = -1; last_acc = -1; first_rv = -1; re_cnt = 0; n_rows = 0; done_cnt = 0;
        busy_after = 0; stall_seen = 0; stall_bad = 0; stall_left = stall_n; w0_first = -1;
        w3_first = -1; w3_cnt = 0; idx_bad = 0;
        for (int i = 0; i < 8; i++) begin
            addr_log[i] = '1;
            row_log[i]  = '1;
            data_log[i] = '1;
        end
        post = 0;
        seen_done = 1'b0;
        k_len = 8'(k);
        start = 1'b1;
        res_ready = 1'b1;
        while (post < 3 && cyc < 400) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (array_clear) begin
                if (clr_first < 0) clr_first = cyc;
                clr_cnt++;
            end
            if (buf_rd_en) begin
                if (rd_cnt == 0) begin
                    first_rd = cyc;
                    if (poke) start = 1'b1;
                end
                if (rd_cnt < 8) addr_log[rd_cnt] = buf_addr;
                rd_cnt++;
            end
            if (accumulate_enable) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
            end
            if (lane(west_inputs, 0) != 0 && w0_first < 0) w0_first = cyc;
            if (lane(west_inputs, N-1) != 0) begin
                if (w3_first < 0) w3_first = cyc;
                w3_cnt++;
            end
            if (read_enable) re_cnt++;
            if (seen_done) begin
                post++;
                if (busy) busy_after++;
            end
            if (done) begin
                done_cnt++;
                seen_done = 1'b1;
                if (poke) start = 1'b1;
            end
            if (res_valid) begin
                if (first_rv < 0) first_rv = cyc;
                if (row_index !== res_row) idx_bad++;
                if (res_row == 32'(stall_row) && stall_left > 0) begin
                    if (stall_left == stall_n) stall_data = res_data;
                    else if (res_data !== stall_data) stall_bad++;
                    stall_seen++;
                    stall_left--;
                    res_ready = 1'b0;
                end else begin
                    res_ready = 1'b1;
                    if (n_rows < 8) begin
                        row_log[n_rows]  = res_row;
                        data_log[n_rows] = res_data;
                    end
                    n_rows++;
                end
            end
            cyc++;
        end
        timeout = (post < 3) ? 1 : 0;
        start = 1'b0;
        res_ready = 1'b1;
    endtask

    task automatic check_job(input string j, input int k, input int stall_n);
        check({j, "_timeout"}, timeout, 0);
        check({j, "_clr_first"}, clr_first, 0);
        check({j, "_clr_cnt"}, clr_cnt, 1);
        check({j, "_rd_cnt"}, rd_cnt, k);
        for (int i = 0; i < k; i++) check($sformatf("%s_addr%0d", j, i), addr_log[i], i);
        check({j, "_acc_cnt"}, acc_cnt, (k > 0) ? k + 2 * N - 1 : 0);
        check({j, "_first_acc"}, first_acc, (k > 0) ? 2 : -1);
        check({j, "_first_rv"}, first_rv, (k > 0) ? k + 2 * N + 1 : 1);
        check({j, "_re_cnt"}, re_cnt, N + stall_n);
        check({j, "_n_rows"}, n_rows, N);
        check({j, "_idx"}, idx_bad, 0);
        for (int r = 0; r < N; r++) begin
            check($sformatf("%s_row%0d", j, r), row_log[r], r);
            check($sformatf("%s_data%0d", j, r), data_log[r], exp_rows[r]);
        end
        check({j, "_done_cnt"}, done_cnt, 1);
        check({j, "_busy_after"}, busy_after, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt, bcnt;
        // job A: A[i][k] per column k, B[k][j] per row k
        mem_a[0] = 64'h0001_0000_0002_0001; mem_a[1] = 64'h0002_0001_0000_0001;
        mem_a[2] = 64'h0003_0000_0001_0001; mem_a[3] = '0;
        mem_b[0] = 64'h0001_0000_0002_0001; mem_b[1] = 64'h0000_0001_0001_0000;
        mem_b[2] = 64'h0003_0001_0000_0002; mem_b[3] = '0;
        exp_rows[0] = 64'h000a_0005_0004_0007; exp_rows[1] = 64'h0000_0001_0001_0000;
        exp_rows[2] = 64'h0005_0001_0004_0004; exp_rows[3] = 64'h0004_0002_0003_0003;

        repeat (3) @(posedge clk);
        #1;
        check("rst_status", {busy, done, buf_rd_en, array_clear, accumulate_enable, read_enable, res_valid}, 7'd0);
        check("rst_addr", buf_addr, 0);
        check("rst_row", {row_index, res_row}, 0);
        check("rst_west", west_inputs, 0);
        check("rst_north", north_inputs, 0);
        check("rst_res_data", res_data, 0);
        @(negedge clk) rst = 1'b1;

        run_job(3, -1, 0, 1'b0);
        check_job("k3", 3, 0);

        // skew: only k=0 carries ones on the west side
        mem_a[0] = 64'h0001_0001_0001_0001; mem_a[1] = '0;
        mem_b[0] = 64'h0001_0002_0003_0004; mem_b[1] = 64'h0005_0006_0007_0008;
        for (int r = 0; r < N; r++) exp_rows[r] = 64'h0001_0002_0003_0004;
        run_job(2, -1, 0, 1'b1);
        check_job("skew", 2, 0);
        check("skew_w0_first", w0_first, 2);
        check("skew_lane3_delay", w3_first - w0_first, 3);
        check("skew_lane3_cnt", w3_cnt, 1);

        // back-pressure at row 2
        mem_a[0] = 64'h0001_0000_0002_0001; mem_a[1] = 64'h0002_0001_0000_0001;
        mem_b[0] = 64'h0001_0000_0002_0001; mem_b[1] = 64'h0000_0001_0001_0000;
        exp_rows[0] = 64'h000a_0005_0004_0007; exp_rows[1] = 64'h0000_0001_0001_0000;
        exp_rows[2] = 64'h0005_0001_0004_0004; exp_rows[3] = 64'h0004_0002_0003_0003;
        run_job(3, 2, 5, 1'b0);
        check_job("stall", 3, 5);
        check("stall_seen", stall_seen, 5);
        check("stall_stable", stall_bad, 0);

        for (int r = 0; r < N; r++) exp_rows[r] = '0;
        run_job(0, -1, 0, 1'b0);
        check_job("k0", 0, 0);

        // reset during FLUSH
        k_len = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("in_flush", {busy, accumulate_enable, buf_rd_en}, 3'b110);
        rst = 1'b0;
        #1;
        check("mid_rst_status", {busy, done, buf_rd_en, array_clear, accumulate_enable, read_enable, res_valid}, 7'd0);
        check("mid_rst_addr_row", {buf_addr, row_index, res_row}, 0);
        check("mid_rst_west", west_inputs, 0);
        check("mid_rst_north", north_inputs, 0);
        check("mid_rst_res_data", res_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        dcnt = 0;
        bcnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check("abandon_done", dcnt, 0);
        check("abandon_busy", bcnt, 0);

        mem_a[0] = 64'h0001_0002_0000_0001; mem_a[1] = 64'h0001_0000_0003_0002;
        mem_b[0] = 64'h0002_0001_0000_0001; mem_b[1] = 64'h0001_0001_0001_0001;
        exp_rows[0] = 64'h0003_0002_0001_0002; exp_rows[1] = 64'h0004_0002_0000_0002;
        exp_rows[2] = 64'h0003_0003_0003_0003; exp_rows[3] = 64'h0004_0003_0002_0003;
        rst = 1'b0;
        #3;
        @(negedge clk) rst = 1'b1;
        run_job(2, -1, 0, 1'b0);
        check_job("after_rst", 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
